// File: rtl/matmul_mac_sequencer.sv
// 2x2 unsigned matrix multiply C = A x B using one multiplier and one accumulator.
// Each result takes two MAC cycles and is handed out through a valid/ready handshake.
module matmul_mac_sequencer #(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 2*W+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [4*W-1:0]   a_flat,
  input  logic [4*W-1:0]   b_flat,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [1:0]       res_idx,
  output logic             done
);

  localparam int unsigned PW = 2*W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL0 = 3'd1,
    S_MUL1 = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [4*W-1:0]   a_q, b_q;
  logic [1:0]       k_q;
  logic [ACC_W-1:0] acc_q;
  logic             load, k_inc;
  logic             phase;
  logic [1:0]       a_sel, b_sel;
  logic [W-1:0]     op_a, op_b;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] acc_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; clear overrides every transition and side effect.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    k_inc   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_MUL0;
        load    = 1'b1;
      end
      S_MUL0: state_d = S_MUL1;
      S_MUL1: state_d = S_EMIT;
      S_EMIT: if (res_ready) begin
        if (k_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL0;
          k_inc   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      load    = 1'b0;
      k_inc   = 1'b0;
    end
  end

  // Operand select: row k[1], column k[0]; MUL1 walks the inner index.
  assign phase   = (state_q == S_MUL1);
  assign a_sel   = {k_q[1], phase};
  assign b_sel   = {phase, k_q[0]};
  assign op_a    = a_q[32'(a_sel)*W +: W];
  assign op_b    = b_q[32'(b_sel)*W +: W];
  assign prod    = PW'(op_a) * PW'(op_b);
  assign acc_sum = acc_q + ACC_W'(prod);
  assign res_idx = k_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= 2'd0;
      acc_q     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (load) begin
        a_q <= a_flat;
        b_q <= b_flat;
      end
      if (state_d == S_IDLE) k_q <= 2'd0;
      else if (k_inc)        k_q <= k_q + 2'd1;
      if (state_q == S_MUL0)      acc_q <= ACC_W'(prod);
      else if (state_q == S_MUL1) acc_q <= acc_sum;
      if (state_q == S_MUL1) res_data <= acc_sum;
      res_valid <= (state_d == S_EMIT);
      done      <= (state_d == S_DONE);
      busy      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// Directed bench for matmul_mac_sequencer: scoreboard of expected (idx, data)
// words built from an independent 2x2 product model, plus latency checks.
module tb_matmul_mac_sequencer;

  localparam int unsigned W     = 8;
  localparam int unsigned ACC_W = 2*W+1;

  typedef struct packed {
    logic [1:0]       idx;
    logic [ACC_W-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             clear;
  logic [4*W-1:0]   a_flat;
  logic [4*W-1:0]   b_flat;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [1:0]       res_idx;
  logic             done;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   emit_cyc[4];
  int   done_cyc;
  int   done_cnt;
  int   nres;

  matmul_mac_sequencer #(.W(W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear     (clear),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int el(input logic [4*W-1:0] v, input int i);
    logic [4*W-1:0] t;
    t = v >> (i*W);
    return int'(t[W-1:0]);
  endfunction

  // Reference: C[r][c] = A[r][0]*B[0][c] + A[r][1]*B[1][c], row-major packing.
  task automatic push_job(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        e.idx  = 2'(r*2 + c);
        e.data = ACC_W'(el(a, r*2) * el(b, c) + el(a, r*2+1) * el(b, 2+c));
        q.push_back(e);
      end
    end
  endtask

  task automatic run_job(input logic [4*W-1:0] a, input logic [4*W-1:0] b,
                         input int stall_len, input bit hazard, input int limit);
    int   stalled;
    exp_t e;
    stalled  = 0;
    a_flat   = a;
    b_flat   = b;
    push_job(a, b);
    nres     = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i < 4; i++) emit_cyc[i] = -1;
    res_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= limit; t++) begin
      if (hazard) begin
        if (t == 1) a_flat = {4{W'(9)}};
        start = (t == 4 || t == 13);
      end
      if (done) begin
        done_cnt++;
        done_cyc = t;
      end
      res_ready = 1'b1;
      if (res_valid) begin
        chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q[0];
          chk("res_idx", 32'(res_idx), 32'(e.idx));
          chk("res_data", 32'(res_data), 32'(e.data));
          if (res_idx == 2'd1 && stalled < stall_len) begin
            res_ready = 1'b0;
            stalled++;
          end else begin
            void'(q.pop_front());
            if (nres < 4) emit_cyc[nres] = t;
            nres++;
          end
        end
      end
      if (t < limit) step();
    end
    start = 1'b0;
  endtask

  task automatic check_job(input int c0, input int c1, input int c2, input int c3, input int dc);
    chk("emit_cyc0", emit_cyc[0], c0);
    chk("emit_cyc1", emit_cyc[1], c1);
    chk("emit_cyc2", emit_cyc[2], c2);
    chk("emit_cyc3", emit_cyc[3], c3);
    chk("done_cyc", done_cyc, dc);
    chk("done_cnt", done_cnt, 1);
    chk("busy_after", 32'(busy), 0);
    chk("sb_left", q.size(), 0);
  endtask

  logic [4*W-1:0] a_basic, b_basic, a_rand, b_rand;
  int             quiet_done;

  initial begin
    a_basic = {W'(4), W'(3), W'(2), W'(1)};
    b_basic = {W'(8), W'(7), W'(6), W'(5)};
    rst = 1'b1; start = 1'b0; clear = 1'b0; res_ready = 1'b1;
    a_flat = '0; b_flat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", 32'(res_data), 0);
    chk("rst_idx", 32'(res_idx), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    step();

    // clear and start together in IDLE: clear wins
    a_flat = a_basic; b_flat = b_basic;
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    chk("clr_start_busy", 32'(busy), 0);
    step();
    chk("clr_start_busy2", 32'(busy), 0);
    chk("clr_start_valid", 32'(res_valid), 0);

    // basic job, ready held high
    run_job(a_basic, b_basic, 0, 1'b0, 16);
    check_job(3, 6, 9, 12, 13);

    // max operands: 255*255*2 = 130050 must not wrap
    run_job({4{W'(255)}}, {4{W'(255)}}, 0, 1'b0, 16);
    check_job(3, 6, 9, 12, 13);

    // backpressure on idx 1 for 5 cycles
    run_job(a_basic, b_basic, 5, 1'b0, 22);
    check_job(3, 11, 14, 17, 18);

    // operand change after start, start pulses during busy and DONE
    run_job(a_basic, b_basic, 0, 1'b1, 20);
    check_job(3, 6, 9, 12, 13);

    // abort during MUL1 of k=2 (cycle 8)
    run_job(a_basic, b_basic, 0, 1'b0, 8);
    chk("abort_nres", nres, 2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(res_valid), 0);
    q.delete();
    quiet_done = 32'(done);
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) quiet_done++;
    end
    chk("abort_no_done", quiet_done, 0);
    chk("abort_idle", 32'(busy), 0);
    run_job(a_basic, b_basic, 0, 1'b0, 16);
    check_job(3, 6, 9, 12, 13);

    // async reset in EMIT of k=1 (cycle 6)
    run_job(a_basic, b_basic, 0, 1'b0, 6);
    chk("pre_rst_valid", 32'(res_valid), 1);
    chk("pre_rst_idx", 32'(res_idx), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(res_valid), 0);
    chk("arst_data", 32'(res_data), 0);
    chk("arst_idx", 32'(res_idx), 0);
    chk("arst_done", 32'(done), 0);
    step();
    rst = 1'b0;
    q.delete();
    step();
    chk("post_rst_busy", 32'(busy), 0);
    run_job({W'(40), W'(30), W'(20), W'(10)}, {W'(4), W'(3), W'(2), W'(1)}, 0, 1'b0, 16);
    check_job(3, 6, 9, 12, 13);

    // random operands
    for (int n = 0; n < 3; n++) begin
      a_rand = $urandom();
      b_rand = $urandom();
      run_job(a_rand, b_rand, 0, 1'b0, 16);
      check_job(3, 6, 9, 12, 13);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
